// File: rtl/arm_pkg.sv
// Shared constants and helpers for the ARM7TDMI datapath.
// Contents:
//   DATA_WIDTH / NUM_REGS / SEL_WIDTH  - register-file geometry
//   CPSR_N/Z/C/V                       - bit positions inside the 4-bit CPSR
//   R0..R15                            - register index constants
//   pack_flags()                       - assembles ALU flags into CPSR order
package arm_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 16;
  localparam int SEL_WIDTH  = 32;
  localparam int IDX_WIDTH  = 4;

  localparam int CPSR_N = 3;
  localparam int CPSR_Z = 2;
  localparam int CPSR_C = 1;
  localparam int CPSR_V = 0;

  localparam logic [IDX_WIDTH-1:0] R0  = 4'd0;
  localparam logic [IDX_WIDTH-1:0] R1  = 4'd1;
  localparam logic [IDX_WIDTH-1:0] R2  = 4'd2;
  localparam logic [IDX_WIDTH-1:0] R3  = 4'd3;
  localparam logic [IDX_WIDTH-1:0] R4  = 4'd4;
  localparam logic [IDX_WIDTH-1:0] R5  = 4'd5;
  localparam logic [IDX_WIDTH-1:0] R6  = 4'd6;
  localparam logic [IDX_WIDTH-1:0] R7  = 4'd7;
  localparam logic [IDX_WIDTH-1:0] R8  = 4'd8;
  localparam logic [IDX_WIDTH-1:0] R9  = 4'd9;
  localparam logic [IDX_WIDTH-1:0] R10 = 4'd10;
  localparam logic [IDX_WIDTH-1:0] R11 = 4'd11;
  localparam logic [IDX_WIDTH-1:0] R12 = 4'd12;
  localparam logic [IDX_WIDTH-1:0] R13 = 4'd13;
  localparam logic [IDX_WIDTH-1:0] R14 = 4'd14;
  localparam logic [IDX_WIDTH-1:0] R15 = 4'd15;

  typedef logic [DATA_WIDTH-1:0] word_t;

  // Places the individual ALU flags at their CPSR bit positions.
  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[CPSR_N] = n;
    f[CPSR_Z] = z;
    f[CPSR_C] = c;
    f[CPSR_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/registers_if.sv
// Bundle of the register-file bus signals shared by decode/writeback
// (master side) and the register file (slave side).
// Signals:
//   read_reg_num1/2 - read port register numbers (bits [3:0] decoded)
//   write_reg       - write register number (bits [3:0] decoded)
//   write_data      - data written on an enabled edge
//   regwrite        - write enable for the register and CPSR
//   *_flag          - ALU flags captured into CPSR on a write
//   read_data1/2    - combinational read results
interface registers_if (input logic clock);
  import arm_pkg::*;

  logic [SEL_WIDTH-1:0]  read_reg_num1;
  logic [SEL_WIDTH-1:0]  read_reg_num2;
  logic [SEL_WIDTH-1:0]  write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  regwrite;
  logic                  zero_flag;
  logic                  carry_flag;
  logic                  overflow_flag;
  logic                  negative_flag;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;

  modport master (
    input  clock,
    output read_reg_num1, read_reg_num2, write_reg, write_data, regwrite,
           zero_flag, carry_flag, overflow_flag, negative_flag,
    input  read_data1, read_data2
  );

  modport slave (
    input  clock,
    input  read_reg_num1, read_reg_num2, write_reg, write_data, regwrite,
           zero_flag, carry_flag, overflow_flag, negative_flag,
    output read_data1, read_data2
  );

endinterface

// File: rtl/registers.sv
// ARM7TDMI general-purpose register file: 16 x 32-bit registers with two
// combinational read ports, one synchronous write port and the 4-bit CPSR
// condition-flag register ([3]=N, [2]=Z, [1]=C, [0]=V).
// Ports:
//   clock, reset            - rising-edge clock, synchronous active-high reset
//   read_reg_num1/2         - read register numbers, only [3:0] decoded
//   write_reg, write_data   - write register number ([3:0]) and data
//   regwrite                - enables both the register write and CPSR load
//   zero/carry/overflow/negative_flag - ALU flags loaded into CPSR
//   read_data1/2            - zero-latency read data (no write bypass)
module registers
  import arm_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [SEL_WIDTH-1:0]  read_reg_num1,
  input  logic [SEL_WIDTH-1:0]  read_reg_num2,
  input  logic [SEL_WIDTH-1:0]  write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  regwrite,
  input  logic                  zero_flag,
  input  logic                  carry_flag,
  input  logic                  overflow_flag,
  input  logic                  negative_flag,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  word_t            regs_q [NUM_REGS];
  word_t            regs_d [NUM_REGS];
  logic [3:0]       CPSR;
  logic [3:0]       cpsr_d;

  logic [IDX_WIDTH-1:0] rd1_idx_s;
  logic [IDX_WIDTH-1:0] rd2_idx_s;
  logic [IDX_WIDTH-1:0] wr_idx_s;

  // Upper select bits are architecturally ignored; fold them into a sink.
  logic unused_sel_s;
  assign unused_sel_s = ^{read_reg_num1[SEL_WIDTH-1:IDX_WIDTH],
                          read_reg_num2[SEL_WIDTH-1:IDX_WIDTH],
                          write_reg[SEL_WIDTH-1:IDX_WIDTH]};

  assign rd1_idx_s = read_reg_num1[IDX_WIDTH-1:0];
  assign rd2_idx_s = read_reg_num2[IDX_WIDTH-1:0];
  assign wr_idx_s  = write_reg[IDX_WIDTH-1:0];

  // Next-state: the addressed register and CPSR load together on regwrite.
  always_comb begin
    regs_d = regs_q;
    cpsr_d = CPSR;
    if (regwrite) begin
      regs_d[wr_idx_s] = write_data;
      cpsr_d           = pack_flags(negative_flag, zero_flag,
                                    carry_flag, overflow_flag);
    end else begin
      cpsr_d = CPSR;
    end
  end

  // State register; reset takes priority over any pending write.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_WIDTH{1'b0}};
      end
      CPSR <= 4'b0000;
    end else begin
      regs_q <= regs_d;
      CPSR   <= cpsr_d;
    end
  end

  // Reads see the stored value only; a same-cycle write appears after the edge.
  assign read_data1 = regs_q[rd1_idx_s];
  assign read_data2 = regs_q[rd2_idx_s];

endmodule

// File: tb/tb_registers.sv
// Scoreboard bench for the register file. The driver applies one
// transaction per cycle shortly after the rising edge, predicts the
// combinational read data and CPSR from a plain array model and queues the
// prediction; a separate monitor samples the DUT on the falling edge and
// compares against the head of the queue.
module tb_registers;
  import arm_pkg::*;

  logic clock;
  logic reset;

  registers_if bus (.clock(clock));

  registers dut (
    .clock         (clock),
    .reset         (reset),
    .read_reg_num1 (bus.read_reg_num1),
    .read_reg_num2 (bus.read_reg_num2),
    .write_reg     (bus.write_reg),
    .write_data    (bus.write_data),
    .regwrite      (bus.regwrite),
    .zero_flag     (bus.zero_flag),
    .carry_flag    (bus.carry_flag),
    .overflow_flag (bus.overflow_flag),
    .negative_flag (bus.negative_flag),
    .read_data1    (bus.read_data1),
    .read_data2    (bus.read_data2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [3:0]  cpsr;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: architectural state as plain arrays.
  logic [31:0] m_regs [16];
  logic [3:0]  m_cpsr;
  bit          m_known;

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  task automatic check32(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, predict visible outputs, then apply the edge.
  task automatic drive(input logic rst, input logic we,
                       input logic [31:0] wr, input logic [31:0] wd,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [3:0] nzcv);
    exp_t e;
    @(posedge clock);
    #1;
    reset             = rst;
    bus.regwrite      = we;
    bus.write_reg     = wr;
    bus.write_data    = wd;
    bus.read_reg_num1 = r1;
    bus.read_reg_num2 = r2;
    bus.negative_flag = nzcv[3];
    bus.zero_flag     = nzcv[2];
    bus.carry_flag    = nzcv[1];
    bus.overflow_flag = nzcv[0];
    if (m_known) begin
      e.rd1  = m_regs[r1 % 16];
      e.rd2  = m_regs[r2 % 16];
      e.cpsr = m_cpsr;
      exp_q.push_back(e);
    end
    if (rst) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
      m_cpsr  = 4'b0000;
      m_known = 1'b1;
    end else if (we) begin
      m_regs[wr % 16] = wd;
      m_cpsr          = nzcv;
    end
  endtask

  // Monitor: compare every predicted response on the falling edge.
  initial begin
    while (!done) begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check32("read_data1", bus.read_data1, e.rd1);
        check32("read_data2", bus.read_data2, e.rd2);
        check32("cpsr", {28'h0, dut.CPSR}, {28'h0, e.cpsr});
      end
    end
  end

  initial begin
    m_known = 1'b0;
    m_cpsr  = 4'b0000;
    reset   = 1'b0;
    bus.regwrite = 1'b0;
    bus.write_reg = 32'h0;
    bus.write_data = 32'h0;
    bus.read_reg_num1 = 32'h0;
    bus.read_reg_num2 = 32'h0;
    bus.negative_flag = 1'b0;
    bus.zero_flag = 1'b0;
    bus.carry_flag = 1'b0;
    bus.overflow_flag = 1'b0;

    // Reset with a competing write: reset must win.
    drive(1'b1, 1'b1, 32'd2, 32'h12345678, 32'd0, 32'd1, 4'b0000);
    // First write after reset; reads of R0/R1 show zero.
    drive(1'b0, 1'b1, 32'd2, 32'h12345678, 32'd0, 32'd1, 4'b0000);
    // Write R0 while R2 is read back.
    drive(1'b0, 1'b1, 32'd0, 32'hABCDEF01, 32'd2, 32'd1, 4'b0000);
    // Flag capture N=1 Z=0 C=1 V=1.
    drive(1'b0, 1'b1, 32'd3, 32'h00000033, 32'd0, 32'd1, 4'b1011);
    // Hold: flags low with write disabled, R5 target must stay untouched.
    drive(1'b0, 1'b0, 32'd5, 32'hDEADBEEF, 32'd5, 32'd7, 4'b0000);
    drive(1'b0, 1'b0, 32'd5, 32'hDEADBEEF, 32'd5, 32'd7, 4'b0000);
    // Read-during-write on R7: old value before the edge, new after.
    drive(1'b0, 1'b1, 32'd7, 32'h00000077, 32'd0, 32'd7, 4'b0100);
    drive(1'b0, 1'b0, 32'd0, 32'h0, 32'd7, 32'd7, 4'b0000);
    // Address aliasing: 0x12 and 0xFFFFFFF2 both decode to R2.
    drive(1'b0, 1'b0, 32'd0, 32'h0, 32'h00000012, 32'hFFFFFFF2, 4'b0000);
    // R15 behaves as an ordinary register.
    drive(1'b0, 1'b1, 32'hF, 32'hCAFEF00D, 32'd15, 32'd15, 4'b0001);
    drive(1'b0, 1'b0, 32'd0, 32'h0, 32'd15, 32'h0000001F, 4'b0000);
    // Mid-operation reset, then everything reads zero.
    drive(1'b1, 1'b0, 32'd0, 32'h0, 32'd2, 32'd7, 4'b0000);
    drive(1'b0, 1'b0, 32'd0, 32'h0, 32'd2, 32'd15, 4'b0000);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            $urandom(), $urandom(), $urandom(), $urandom(),
            4'($urandom_range(0, 15)));
    end
    drive(1'b0, 1'b0, 32'd0, 32'h0, 32'd0, 32'd1, 4'b0000);

    // Drain: the monitor must consume every prediction.
    repeat (3) @(posedge clock);
    check32("queue_drained", 32'(exp_q.size()), 32'd0);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
